// File: rtl/perf_bcd_display.sv
// Samples a binary performance value periodically and converts it to packed BCD
// with an iterative double-dabble engine, saturating to all nines when out of range.
module perf_bcd_display #(
    parameter int unsigned IN_W         = 32,
    parameter int unsigned DIGITS       = 6,
    parameter int unsigned SAMPLE_DIV_W = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       value,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   digits_flat,
    output logic                  overflow,
    output logic                  valid,
    output logic                  busy
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned ITER_W = $clog2(IN_W + 1);
    localparam logic [ITER_W-1:0] LastIter = ITER_W'(IN_W - 1);
    localparam logic [BCD_W-1:0]  AllNines = {DIGITS{4'h9}};

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e                  state_q;
    logic [SAMPLE_DIV_W-1:0] div_q;
    logic                    tick;
    logic [IN_W-1:0]         bin_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        digits_q;
    logic [ITER_W-1:0]       iter_q;
    logic                    ovf_acc_q;
    logic                    overflow_q;
    logic                    valid_q;
    logic                    busy_q;

    assign tick = &div_q;

    // Per-digit add-3 correction; no carry between digits.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + SAMPLE_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_acc_q  <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Ticks are only honoured here, so a tick while busy is dropped.
                    if (tick && !hold) begin
                        bin_q     <= value;
                        bcd_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        iter_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StConvert;
                    end
                end
                StConvert: begin
                    {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                    ovf_acc_q      <= ovf_acc_q | bcd_adj[BCD_W-1];
                    if (iter_q == LastIter) begin
                        state_q <= StCommit;
                    end else begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                StCommit: begin
                    digits_q   <= ovf_acc_q ? AllNines : bcd_q;
                    overflow_q <= ovf_acc_q;
                    valid_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign digits_flat = digits_q;
    assign overflow    = overflow_q;
    assign valid       = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_perf_bcd_display.sv
// Directed bench for perf_bcd_display: a scoreboard queue holds the expected
// {overflow, digits} of each capture and is popped on every valid pulse.
module tb_perf_bcd_display;

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic        hold;
    logic [23:0] digits_flat;
    logic        overflow;
    logic        valid;
    logic        busy;

    int checks = 0;
    int passed = 0;
    logic [24:0] exp_q[$];

    perf_bcd_display #(
        .IN_W         (32),
        .DIGITS       (6),
        .SAMPLE_DIV_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .hold        (hold),
        .digits_flat (digits_flat),
        .overflow    (overflow),
        .valid       (valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference conversion: decimal digits by division, saturating at 10^6.
    function automatic logic [24:0] model(input logic [31:0] v);
        logic [23:0] r;
        logic [31:0] t;
        if (v >= 32'd1000000) return {1'b1, 24'h999999};
        t = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic push(input logic [31:0] v);
        exp_q.push_back(model(v));
    endtask

    // Edges until busy is seen high, bounded.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Waits for a valid pulse, compares against the scoreboard, checks pulse width.
    task automatic wait_commit(input string tag, output int n);
        logic [24:0] e;
        n = 0;
        while (valid !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid_seen"}, valid, 1'b1);
        if (valid === 1'b1) begin
            check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_digits"}, digits_flat, e[23:0]);
                check({tag, "_overflow"}, overflow, e[24]);
            end
            @(posedge clk);
            #1;
            check({tag, "_valid_width"}, valid, 1'b0);
        end
    endtask

    initial begin
        int n;
        logic seen_busy;
        logic seen_valid;
        rst   = 1'b0;
        value = 32'd0;
        hold  = 1'b0;

        #23;
        check("rst_digits", digits_flat, 24'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        @(negedge clk);
        push(32'd0);
        rst = 1'b1;
        wait_busy(n);
        check("first_busy_edge", n, 64);
        wait_commit("zero", n);
        check("zero_commit_latency", n, 33);

        value = 32'h0001E240;
        push(value);
        wait_commit("v123456", n);

        value = 32'h000F423F;
        push(value);
        wait_commit("v999999", n);

        value = 32'h000F4240;
        push(value);
        wait_commit("v1000000", n);

        value = 32'hFFFFFFFF;
        push(value);
        wait_commit("vmax", n);

        // Value changes two edges after capture must not leak into the result.
        value = 32'd123456;
        push(value);
        wait_busy(n);
        check("chg_capture", busy, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        value = 32'd42;
        wait_commit("chg_old", n);
        push(32'd42);
        wait_commit("chg_new", n);

        // Hold across at least one tick: nothing starts, display stays.
        hold       = 1'b1;
        seen_busy  = 1'b0;
        seen_valid = 1'b0;
        repeat (104) begin
            @(posedge clk);
            #1;
            seen_busy  = seen_busy | busy;
            seen_valid = seen_valid | valid;
        end
        check("hold_no_busy", seen_busy, 1'b0);
        check("hold_no_valid", seen_valid, 1'b0);
        check("hold_digits", digits_flat, 24'h000042);

        // Hold raised mid-conversion does not abort it.
        value = 32'd7;
        push(value);
        hold = 1'b0;
        wait_busy(n);
        check("holdmid_capture", busy, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b1;
        wait_commit("holdmid", n);
        hold = 1'b0;

        // Asynchronous reset at iteration 10 discards the conversion.
        value = 32'd555;
        wait_busy(n);
        check("rstmid_capture", busy, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_digits", digits_flat, 24'h0);
        check("rstmid_overflow", overflow, 1'b0);
        check("rstmid_valid", valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        seen_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen_valid = seen_valid | valid;
        end
        check("rstmid_no_valid", seen_valid, 1'b0);
        @(negedge clk);
        push(32'd555);
        rst = 1'b1;
        wait_busy(n);
        check("rerelease_busy_edge", n, 64);
        wait_commit("after_rst", n);
        check("after_rst_latency", n, 33);

        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/perf_bcd_display.md
Name: perf_bcd_display

Overview:
- Downstream stage of the TSP solver. Periodically samples the solver's 32-bit binary performance value and converts it to packed BCD with an iterative double-dabble engine.
- Drives the six seg7 decoders, so the HEX display shows decimal instead of raw hex nibbles.
- Owns the display-refresh divider and the freeze (hold) control.
- Reports saturation when the value exceeds the displayable range.

Parameters:
- IN_W, 32: width of the binary input value.
- DIGITS, 6: number of BCD digits produced, one per HEX display.
- SAMPLE_DIV_W, 25: sample-divider width; sample period is 2^SAMPLE_DIV_W cycles. Must satisfy 2^SAMPLE_DIV_W > IN_W+2.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst, input, 1: reset; asynchronous, active-low.
- value, input, IN_W: binary value to display; driven by the tsp performance output.
- hold, input, 1: when 1, suppresses new captures; the displayed value freezes.
- digits_flat, output, 4*DIGITS: packed BCD. Digit 0 (least significant) is bits [3:0]; digit k is bits [4k+3:4k].
- overflow, output, 1: 1 when the last committed value was >= 10^DIGITS.
- valid, output, 1: one-cycle pulse on each commit of new digits.
- busy, output, 1: 1 while a conversion is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - Divider counter = 0; FSM = IDLE.
  - digits_flat = 0, overflow = 0, valid = 0, busy = 0.
  - Shift registers cleared.
  - Takes effect immediately, including mid-conversion. The aborted conversion is discarded; nothing is committed.
- Divider:
  - Free-running SAMPLE_DIV_W-bit up-counter that wraps.
  - The sample tick is the edge on which counter == 2^SAMPLE_DIV_W-1.
  - First tick occurs on the 2^SAMPLE_DIV_W-th edge after reset release.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - On a tick with hold=0: capture value into the binary shift register, clear the BCD working register (4*DIGITS bits) and the overflow accumulator, clear the iteration counter, set busy=1, and go to CONVERT.
  - A tick with hold=1 does nothing.
- CONVERT, one iteration per edge, IN_W edges total:
  - (a) Add 3 to every BCD digit that is >= 5.
  - (b) Shift the {BCD, binary} register left by 1. The binary MSB enters the BCD LSB.
  - (c) If the bit shifted out of the BCD MSB is 1, set the overflow accumulator.
  - After the IN_W-th iteration, go to COMMIT.
- COMMIT (one edge):
  - If the accumulator is 0: digits_flat = BCD register, overflow = 0.
  - If the accumulator is 1: digits_flat = all digits 9 (saturate), overflow = 1.
  - valid = 1 for exactly this following cycle; busy = 0; go to IDLE.
- Latency: capture edge E0, iterations E1..E32 (for IN_W=32), commit on E33. valid and the new digits are visible after E33.
- value changes after E0 do not affect the result.
- hold changes mid-conversion do not abort it; hold gates capture only.
- A tick while busy is ignored. The parameter constraint makes this unreachable; the RTL must still be safe.
- digits_flat and overflow are stable between commits.
- All arithmetic is unsigned. Per-digit add-3 is 4-bit, with no inter-digit carry.

Test Plan:
- Config: SAMPLE_DIV_W=6, IN_W=32, DIGITS=6.
- Reset release, value=0:
  - Outputs are 0 during reset.
  - First busy rise on edge 64.
  - valid pulses once after edge 97; digits_flat=24'h000000, overflow=0.
- value=32'h0001E240 (123456):
  - Next commit gives digits_flat=24'h123456, overflow=0.
  - valid is exactly 1 cycle wide.
- Range boundaries:
  - value=32'h000F423F (999999) gives 24'h999999, overflow=0.
  - value=32'h000F4240 (1000000) gives 24'h999999, overflow=1.
  - value=32'hFFFFFFFF gives 24'h999999, overflow=1.
- Input changes:
  - Change value from 123456 to 42 two edges after capture: commit shows 24'h123456. Next sample shows 24'h000042.
  - Assert hold=1 across a tick: no busy, no valid, digits unchanged.
  - Assert hold=1 mid-conversion: conversion still commits.
- Reset mid-conversion:
  - Drive rst=0 at iteration 10: all outputs 0 asynchronously, with no valid pulse.
  - After release, the first tick again occurs at edge 64.
